// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word fall-through output; the default build uses a registered read port.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // A read at empty is never accepted, so a write at full only goes in alongside a real read.
  always_comb begin
    rd_acc = rd_en && (count != '0) && !flush;
    wr_acc = wr_en && ((count != CNT_MAX) || rd_acc) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  // A new error event takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc && !flush) overflow <= 1'b1;
      else if (err_clr)               overflow <= 1'b0;
      if (rd_en && !rd_acc && !flush) underflow <= 1'b1;
      else if (err_clr)               underflow <= 1'b0;
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == CNT_MAX);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (DEPTH=16, DATA_W=8): stimulus pushes hand-known read data,
// a monitor pops and compares whenever the FIFO presents a word.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [4:0] count;
  logic       empty, full, almost_empty, almost_full;
  logic       overflow, underflow;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_sync_param #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; returns shortly after the edge that applies them.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f = 1'b0, input logic e = 1'b0, input logic rs = 1'b1);
    @(negedge clk); #1;
    wr_en = w; data_in = d; rd_en = r; flush = f; err_clr = e; rst_n = rs;
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic rd_exp(input logic [7:0] e);
    exp_q.push_back(e);
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: samples mid-cycle, after inputs settle and before the next edge.
  initial begin
    logic [7:0] e;
    logic       present;
    forever begin
      @(negedge clk); #3;
`ifdef FIFO_FWFT_EN
      present = rst_n && !flush && rd_en && rd_valid;
`else
      present = rd_valid;
`endif
      if (present) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 0x%0h expected no word at %0t", data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", int'(data_out), int'(e));
        end
      end
    end
  end

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
`ifndef FIFO_FWFT_EN
    chk("rst_data_out", int'(data_out), 0);
`endif

    // Fill 0x01..0x10; AF from 14, AE cleared at 3.
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      chk("fill_count", int'(count), i);
      chk("fill_af", int'(almost_full), (i >= 14) ? 1 : 0);
      chk("fill_ae", int'(almost_empty), (i <= 2) ? 1 : 0);
      chk("fill_ovf", int'(overflow), 0);
    end
    chk("full_flag", int'(full), 1);
    wr(8'hEE);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);

    // Drain: 0xEE must never emerge.
    for (int i = 1; i <= 16; i++) rd_exp(8'(i));
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    chk("drain_udf", int'(underflow), 0);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_set", int'(underflow), 1);
    chk("udf_empty", int'(empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_udf", int'(underflow), 0);

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    chk("full2", int'(full), 1);
    exp_q.push_back(8'h20);
    step(1'b1, 8'hAA, 1'b1);
    chk("rw_full_count", int'(count), 16);
    chk("rw_full_ovf", int'(overflow), 0);
    for (int i = 1; i < 16; i++) rd_exp(8'(8'h20 + i));
    rd_exp(8'hAA);
    chk("rw_full_drain", int'(count), 0);

    // Simultaneous read/write at empty: write wins, read rejected.
    step(1'b1, 8'h55, 1'b1);
    chk("rw_empty_count", int'(count), 1);
    chk("rw_empty_udf", int'(underflow), 1);
    rd_exp(8'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr2_ovf", int'(overflow), 0);
    chk("clr2_udf", int'(underflow), 0);

    // Flush with concurrent wr/rd ignored.
    for (int i = 0; i < 10; i++) wr(8'(8'h60 + i));
    chk("pre_flush_count", int'(count), 10);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_udf", int'(underflow), 0);
    wr(8'h77);
    rd_exp(8'h77);
    chk("post_flush_count", int'(count), 0);

    // Three full pointer wraps with four words in flight.
    for (int k = 0; k < 48; k++) begin
      if (k < 4) begin
        wr(8'(k * 3 + 1));
      end else begin
        exp_q.push_back(8'((k - 4) * 3 + 1));
        step(1'b1, 8'(k * 3 + 1), 1'b1);
        chk("wrap_count", int'(count), 4);
      end
    end
    for (int k = 44; k < 48; k++) rd_exp(8'(k * 3 + 1));
    chk("wrap_drained", int'(count), 0);

    // Reset in the middle of operation.
    for (int i = 0; i < 7; i++) wr(8'(8'hC0 + i));
    chk("pre_rst_count", int'(count), 7);
    step(1'b1, 8'hC7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_udf", int'(underflow), 0);

`ifdef FIFO_FWFT_EN
    wr(8'h3C);
    chk("fwft_data", int'(data_out), 8'h3C);
    chk("fwft_valid", int'(rd_valid), 1);
    rd_exp(8'h3C);
    chk("fwft_empty", int'(rd_valid), 0);
`else
    wr(8'h3C);
    chk("std_no_valid", int'(rd_valid), 0);
    rd_exp(8'h3C);
`endif

    idle();
    idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
